// File: rtl/vt_spi_session_master.sv
// SPI session master: one 64-bit full-duplex frame per START, CS framed with setup/hold/gap guard times.
// Latency: START->DONE = 1+SETUP_CYC+128*HALF_PERIOD+HOLD_CYC cycles; no backpressure, START is ignored unless idle.
module vt_spi_session_master #(
    parameter int HALF_PERIOD = 5,
    parameter int SETUP_CYC   = 2,
    parameter int HOLD_CYC    = 1,
    parameter int GAP_CYC     = 152
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [63:0] TXDATA,
    input  logic        SPI_MISO,
    output logic        SPI_CS,
    output logic        SPI_CLK,
    output logic        SPI_MOSI,
    output logic [63:0] RXDATA,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [9:0] SETUP_LAST = 10'(SETUP_CYC - 1);
    localparam logic [9:0] HOLD_LAST  = 10'(HOLD_CYC - 1);
    localparam logic [9:0] GAP_LAST   = 10'(GAP_CYC - 1);
    localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);

    state_t      state;
    logic [63:0] tx_sr;     // bits still to be sent after the one on SPI_MOSI
    logic [63:0] rx_sr;
    logic [9:0]  cyc_cnt;
    logic [7:0]  phase_cnt;
    logic [6:0]  bit_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tx_sr     <= 64'h0;
            rx_sr     <= 64'h0;
            cyc_cnt   <= 10'd0;
            phase_cnt <= 8'd0;
            bit_cnt   <= 7'd0;
            SPI_CS    <= 1'b1;
            SPI_CLK   <= 1'b0;
            SPI_MOSI  <= 1'b0;
            RXDATA    <= 64'h0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        tx_sr    <= {TXDATA[62:0], 1'b0};
                        SPI_MOSI <= TXDATA[63];
                        rx_sr    <= 64'h0;
                        cyc_cnt  <= 10'd0;
                        bit_cnt  <= 7'd0;
                        SPI_CS   <= 1'b0;
                        BUSY     <= 1'b1;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    if (cyc_cnt == SETUP_LAST) begin
                        cyc_cnt   <= 10'd0;
                        phase_cnt <= 8'd0;
                        state     <= SHIFT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 10'd1;
                    end
                end

                SHIFT: begin
                    if (phase_cnt != PHASE_LAST) begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end else begin
                        phase_cnt <= 8'd0;
                        if (!SPI_CLK) begin
                            // Rising edge: capture MISO alongside the edge we drive
                            SPI_CLK <= 1'b1;
                            rx_sr   <= {rx_sr[62:0], SPI_MISO};
                            bit_cnt <= bit_cnt + 7'd1;
                        end else begin
                            SPI_CLK <= 1'b0;
                            if (bit_cnt == 7'd64) begin
                                SPI_MOSI <= 1'b0;
                                bit_cnt  <= 7'd0;
                                cyc_cnt  <= 10'd0;
                                state    <= HOLD;
                            end else begin
                                SPI_MOSI <= tx_sr[63];
                                tx_sr    <= {tx_sr[62:0], 1'b0};
                            end
                        end
                    end
                end

                HOLD: begin
                    if (cyc_cnt == HOLD_LAST) begin
                        SPI_CS  <= 1'b1;
                        RXDATA  <= rx_sr;
                        DONE    <= 1'b1;
                        cyc_cnt <= 10'd0;
                        state   <= GAP;
                    end else begin
                        cyc_cnt <= cyc_cnt + 10'd1;
                    end
                end

                GAP: begin
                    // The DONE cycle is the first of the GAP_CYC busy cycles
                    if (cyc_cnt == GAP_LAST) begin
                        BUSY    <= 1'b0;
                        cyc_cnt <= 10'd0;
                        state   <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 10'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vt_spi_session_master.sv
// Directed bench for vt_spi_session_master: default timing instance (a) and fastest timing instance (b).
module tb_vt_spi_session_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, miso_val, loop_a;
    logic [63:0] txdata;

    logic        cs_a, sclk_a, mosi_a, busy_a, done_a, miso_a;
    logic [63:0] rxdata_a;
    logic        cs_b, sclk_b, mosi_b, busy_b, done_b, miso_b;
    logic [63:0] rxdata_b;

    assign miso_a = loop_a ? mosi_a : miso_val;
    assign miso_b = mosi_b;

    vt_spi_session_master u_dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .TXDATA(txdata), .SPI_MISO(miso_a),
        .SPI_CS(cs_a), .SPI_CLK(sclk_a), .SPI_MOSI(mosi_a), .RXDATA(rxdata_a),
        .BUSY(busy_a), .DONE(done_a)
    );

    vt_spi_session_master #(
        .HALF_PERIOD(1), .SETUP_CYC(1), .HOLD_CYC(1)
    ) u_dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .TXDATA(txdata), .SPI_MISO(miso_b),
        .SPI_CS(cs_b), .SPI_CLK(sclk_b), .SPI_MOSI(mosi_b), .RXDATA(rxdata_b),
        .BUSY(busy_b), .DONE(done_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Bus monitors, sampled on the falling edge
    logic        prev_a = 1'b0, hi_mosi_a = 1'b0;
    int          rise_a = 0, stab_err_a = 0, done_cyc_a = 0;
    logic [63:0] mosi_vec_a = 64'h0;

    always @(negedge clk) begin
        prev_a <= sclk_a;
        if (sclk_a && !prev_a) begin
            rise_a     <= rise_a + 1;
            mosi_vec_a <= {mosi_vec_a[62:0], mosi_a};
            hi_mosi_a  <= mosi_a;
        end else if (sclk_a && prev_a && (mosi_a !== hi_mosi_a)) begin
            stab_err_a <= stab_err_a + 1;
        end
        if (done_a) done_cyc_a <= done_cyc_a + 1;
    end

    logic prev_b = 1'b0;
    int   rise_b = 0, tog_b = 0, spc_err_b = 0, since_b = 1000;

    always @(negedge clk) begin
        prev_b <= sclk_b;
        if (sclk_b !== prev_b) tog_b <= tog_b + 1;
        if (sclk_b && !prev_b) begin
            rise_b  <= rise_b + 1;
            since_b <= 1;
            if (since_b != 2 && since_b < 100) spc_err_b <= spc_err_b + 1;
        end else if (since_b < 1000) begin
            since_b <= since_b + 1;
        end
    end

    // Issue one START; TXDATA is scrambled right after acceptance
    task automatic kick(input bit sel, input logic [63:0] tx);
        @(posedge clk); #1;
        txdata = tx;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        txdata  = ~tx;
        @(negedge clk);
        chk("accept_cs", sel ? cs_b : cs_a, 64'd0);
        chk("accept_busy", sel ? busy_b : busy_a, 64'd1);
    endtask

    // Returns cycles from the START cycle to DONE (accept edge counts as 1)
    task automatic wait_done(input bit sel, input int pulse_at, output int lat);
        lat = 1;
        while (!(sel ? done_b : done_a) && lat < 2000) begin
            @(posedge clk);
            lat++;
            #1 start_a = (pulse_at > 0 && lat == pulse_at);
            @(negedge clk);
        end
        start_a = 1'b0;
        if (!(sel ? done_b : done_a)) lat = -1;
    endtask

    // Called in the DONE cycle; returns cycles until BUSY drops
    task automatic wait_gap(input bit sel, input bit poke, output int g);
        if (poke) start_a = 1'b1;
        g = 0;
        do begin
            @(posedge clk);
            g++;
            #1 start_a = 1'b0;
            @(negedge clk);
        end while ((sel ? busy_b : busy_a) && g < 2000);
    endtask

    int lat, g, base, dc, tb0, sb0, n;

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        txdata = 64'h0; miso_val = 1'b0; loop_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs", cs_a, 64'd1);
        chk("rst_sclk", sclk_a, 64'd0);
        chk("rst_mosi", mosi_a, 64'd0);
        chk("rst_busy", busy_a, 64'd0);
        chk("rst_done", done_a, 64'd0);
        chk("rst_rxdata", rxdata_a, 64'h0);
        chk("rst_cs_b", cs_b, 64'd1);

        // Loopback with a sparse frame: MOSI high only in bit periods 5 and 32
        base = rise_a; dc = done_cyc_a;
        kick(0, 64'h0800_0001_0000_0000);
        wait_done(0, 0, lat);
        chk("lat_default", 64'(lat), 64'd644);
        chk("rx_loop1", rxdata_a, 64'h0800_0001_0000_0000);
        wait_gap(0, 0, g);
        chk("gap1", 64'(g), 64'd152);
        #1;
        chk("rises1", 64'(rise_a - base), 64'd64);
        chk("mosi_bits1", mosi_vec_a, 64'h0800_0001_0000_0000);
        chk("mosi_stable1", 64'(stab_err_a), 64'd0);
        chk("done_width1", 64'(done_cyc_a - dc), 64'd1);
        chk("rx_hold1", rxdata_a, 64'h0800_0001_0000_0000);

        // MISO held high, then held low
        loop_a = 1'b0; miso_val = 1'b1;
        kick(0, 64'h0123_4567_89AB_CDEF);
        wait_done(0, 0, lat);
        chk("rx_ones", rxdata_a, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_gap(0, 0, g);
        chk("gap_ones", 64'(g), 64'd152);
        miso_val = 1'b0;
        kick(0, 64'hFFFF_0000_FFFF_0000);
        chk("rx_hold_ones", rxdata_a, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(0, 0, lat);
        chk("rx_zeros", rxdata_a, 64'h0);
        wait_gap(0, 0, g);
        chk("gap_zeros", 64'(g), 64'd152);

        // START during SHIFT and during the DONE cycle must be dropped
        loop_a = 1'b1;
        base = rise_a;
        kick(0, 64'hDEAD_BEEF_0F0F_1234);
        wait_done(0, 300, lat);
        chk("lat_ignore", 64'(lat), 64'd644);
        chk("rx_ignore", rxdata_a, 64'hDEAD_BEEF_0F0F_1234);
        wait_gap(0, 1, g);
        chk("gap_ignore", 64'(g), 64'd152);
        repeat (5) @(negedge clk);
        chk("noqueue_cs", cs_a, 64'd1);
        chk("noqueue_busy", busy_a, 64'd0);
        #1;
        chk("rises_ignore", 64'(rise_a - base), 64'd64);

        // START together with RST is not accepted
        @(posedge clk); #1;
        rst = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_a = 1'b0;
        @(negedge clk);
        chk("rststart_busy", busy_a, 64'd0);
        chk("rststart_cs", cs_a, 64'd1);
        chk("rststart_rx", rxdata_a, 64'h0);
        @(negedge clk);
        chk("rststart_busy2", busy_a, 64'd0);

        // Abort at the 30th SPI_CLK rise
        base = rise_a; dc = done_cyc_a;
        kick(0, 64'hCAFE_F00D_1357_9BDF);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((rise_a - base) < 30 && n < 2000);
        chk("abort_reached", 64'(rise_a - base), 64'd30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cs", cs_a, 64'd1);
        chk("abort_sclk", sclk_a, 64'd0);
        chk("abort_busy", busy_a, 64'd0);
        repeat (800) @(negedge clk);
        #1;
        chk("abort_nodone", 64'(done_cyc_a - dc), 64'd0);
        chk("abort_rx", rxdata_a, 64'h0);
        kick(0, 64'h1234_5678_9ABC_DEF0);
        wait_done(0, 0, lat);
        chk("lat_after_abort", 64'(lat), 64'd644);
        chk("rx_after_abort", rxdata_a, 64'h1234_5678_9ABC_DEF0);
        wait_gap(0, 0, g);

        // Fastest timing instance
        base = rise_b; tb0 = tog_b; sb0 = spc_err_b;
        kick(1, 64'hA5A5_5A5A_0123_4567);
        wait_done(1, 0, lat);
        chk("lat_fast", 64'(lat), 64'd131);
        chk("rx_fast", rxdata_b, 64'hA5A5_5A5A_0123_4567);
        wait_gap(1, 0, g);
        chk("gap_fast", 64'(g), 64'd152);
        #1;
        chk("rises_fast", 64'(rise_b - base), 64'd64);
        chk("toggles_fast", 64'(tog_b - tb0), 64'd128);
        chk("spacing_fast", 64'(spc_err_b - sb0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/vt_spi_session_master.md
VT_SPI_SESSION_MASTER -- requirements
Module: vt_spi_session_master

Interface
REQ-001 SHALL provide parameter HALF_PERIOD, default 5: CLK cycles per SPI_CLK phase (low or high), legal range 1..255.
REQ-002 SHALL provide parameter SETUP_CYC, default 2: CLK cycles from SPI_CS falling to the first SPI_CLK rise, legal range 1..255.
REQ-003 SHALL provide parameter HOLD_CYC, default 1: CLK cycles from the last SPI_CLK fall to SPI_CS rising, legal range 1..255.
REQ-004 SHALL provide parameter GAP_CYC, default 152: minimum CLK cycles SPI_CS stays high before the next session, legal range 1..1023.
REQ-005 SHALL have port CLK, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port START, input, 1 bit: one-cycle session request.
REQ-008 SHALL have port TXDATA, input, 64 bits: command frame, shifted out MSB (bit 63) first.
REQ-009 SHALL have port SPI_MISO, input, 1 bit: readback data from the sensor.
REQ-010 SHALL have port SPI_CS, output, 1 bit: active-low chip select.
REQ-011 SHALL have port SPI_CLK, output, 1 bit: gated SPI clock, idle low.
REQ-012 SHALL have port SPI_MOSI, output, 1 bit: serial command data.
REQ-013 SHALL have port RXDATA, output, 64 bits: captured readback frame, first-received bit at bit 63.
REQ-014 SHALL have port BUSY, output, 1 bit: high from START acceptance through the end of GAP.
REQ-015 SHALL have port DONE, output, 1 bit: one-cycle pulse when RXDATA is valid.

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, SHIFT, HOLD and GAP; every output SHALL be registered.
REQ-017 IDLE: START=1 SHALL latch TXDATA into the TX shift register and move to SETUP; in the next cycle SPI_CS=0 and BUSY=1.
REQ-018 SETUP SHALL last SETUP_CYC cycles with SPI_CLK=0 and SPI_MOSI=TXDATA[63], then move to SHIFT.
REQ-019 SHIFT SHALL emit exactly 64 bit periods; each bit period is HALF_PERIOD cycles with SPI_CLK=0, then HALF_PERIOD cycles with SPI_CLK=1.
REQ-020 SPI_MOSI SHALL change only on the cycle SPI_CLK returns low, presenting the next bit; it SHALL be stable throughout each high phase.
REQ-021 SPI_MISO SHALL be sampled on the CLK edge that drives SPI_CLK high; it SHALL be shifted into the RX shift register LSB-in, so that after 64 samples the first sample is at bit 63.
REQ-022 A 7-bit bit counter SHALL count rising SPI_CLK edges; after the 64th high phase, SPI_CLK SHALL return low and the FSM SHALL move to HOLD (no 65th edge).
REQ-023 HOLD SHALL last HOLD_CYC cycles with SPI_CS=0, SPI_CLK=0 and SPI_MOSI=0.
REQ-024 On HOLD exit: SPI_CS=1, RXDATA is updated from the RX shift register, DONE=1 for exactly one cycle, and the FSM moves to GAP.
REQ-025 GAP SHALL last GAP_CYC cycles with BUSY=1, then the FSM moves to IDLE with BUSY=0.
REQ-026 START SHALL be ignored (not queued) in any state other than IDLE, including the cycle DONE is high.
REQ-027 Changes to TXDATA after START acceptance SHALL have no effect on the session in progress.
REQ-028 RXDATA SHALL hold its value between DONE pulses; it SHALL change only in the DONE cycle.
REQ-029 Session length from START to DONE SHALL be 1+SETUP_CYC+128*HALF_PERIOD+HOLD_CYC cycles; with defaults this is 644.

Reset
REQ-030 RST=1 SHALL, on the next CLK edge and in any state, force: FSM=IDLE, SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, BUSY=0, DONE=0, RXDATA=64'h0, and all counters and shift registers =0.
REQ-031 Reset mid-session SHALL abort without a DONE pulse and without updating RXDATA; SPI_CLK SHALL NOT produce a truncated high phase after the reset edge.
REQ-032 START asserted together with RST SHALL be ignored; the first START accepted SHALL be one sampled with RST=0.

Verification
REQ-033 Defaults, TXDATA=64'h0800_0001_0000_0000, MISO tied to MOSI -> SPI_MOSI is high only during bit periods 5 and 32; exactly 64 SPI_CLK rises occur; DONE occurs 644 cycles after START; RXDATA=64'h0800_0001_0000_0000.
REQ-034 SPI_MISO held at 1, then a second session with SPI_MISO held at 0 -> RXDATA=64'hFFFF_FFFF_FFFF_FFFF after the first DONE and 64'h0 after the second; BUSY stays high for GAP_CYC cycles after each DONE.
REQ-035 START pulsed during SHIFT and again in the DONE cycle -> no effect; the SPI_CLK edge count stays 64; the next START in IDLE is accepted.
REQ-036 RST asserted at SPI_CLK rise 30 -> SPI_CS=1 and SPI_CLK=0 on the next edge; no DONE pulse; RXDATA=0; a new session then completes normally.
REQ-037 HALF_PERIOD=1, SETUP_CYC=1, HOLD_CYC=1 -> SPI_CLK toggles every cycle; DONE occurs 131 cycles after START; loopback RXDATA equals TXDATA for 64'hA5A5_5A5A_0123_4567.
